// File: rtl/rast_pkg.sv
// Shared rasteriser types: depth-function encoding, default fragment geometry,
// the fragment payload struct and the dispatcher FSM state encoding.
package rast_pkg;

  localparam int unsigned Z_W     = 8;
  localparam int unsigned X_W     = 2;
  localparam int unsigned Y_W     = 2;
  localparam int unsigned COLOR_W = 16;

  typedef enum logic [2:0] {
    Z_NEVER    = 3'd0,
    Z_LESS     = 3'd1,
    Z_EQUAL    = 3'd2,
    Z_LEQUAL   = 3'd3,
    Z_GREATER  = 3'd4,
    Z_NOTEQUAL = 3'd5,
    Z_GEQUAL   = 3'd6,
    Z_ALWAYS   = 3'd7
  } z_func_t;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [Z_W-1:0]     z;
    logic [COLOR_W-1:0] color;
  } frag_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_TEST_WAIT  = 2'd1,
    ST_EMIT       = 2'd2,
    ST_FLUSH_WAIT = 2'd3
  } disp_state_t;

endpackage

// File: rtl/frag_fifo.sv
// Fragment FIFO: power-of-two depth, show-ahead read (data_o is the head entry).
// Ports: clk_i, rst_ni, push_i/data_i (write), pop_i (consume head), data_o,
//        full_o, empty_o, count_o (current occupancy).
module frag_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage needs no reset; occupancy tracking makes stale entries invisible.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/z_test_dispatcher.sv
// Upstream sequencer for z_buffer: queues fragments, issues one depth test or
// buffer flush at a time, forwards passing fragments over valid/ready.
// Ports: clk_i/rst_ni; frag_* upstream valid/ready; depth_func_i; flush_req_i,
//        flush_busy_o; zb_* command/response to z_buffer; out_* downstream.
// Optional: define Z_TEST_STATS_EN to add stat_pass_o/stat_fail_o counters.
module z_test_dispatcher
  import rast_pkg::*;
#(
  parameter int unsigned Z_SIZE       = Z_W,
  parameter int unsigned X_PIXEL_SIZE = X_W,
  parameter int unsigned Y_PIXEL_SIZE = Y_W,
  parameter int unsigned COLOR_SIZE   = COLOR_W,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    frag_valid_i,
  output logic                    frag_ready_o,
  input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
  input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
  input  logic [Z_SIZE-1:0]       frag_z_i,
  input  logic [COLOR_SIZE-1:0]   frag_color_i,
  input  logic [2:0]              depth_func_i,
  input  logic                    flush_req_i,
  output logic                    flush_busy_o,
  output logic                    zb_start_o,
  output logic                    zb_flush_o,
  output logic [X_PIXEL_SIZE-1:0] zb_x_o,
  output logic [Y_PIXEL_SIZE-1:0] zb_y_o,
  output logic [Z_SIZE-1:0]       zb_z_o,
  output logic [2:0]              zb_func_o,
  input  logic                    zb_done_i,
  input  logic                    zb_pass_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [X_PIXEL_SIZE-1:0] out_x_o,
  output logic [Y_PIXEL_SIZE-1:0] out_y_o,
  output logic [Z_SIZE-1:0]       out_z_o,
  output logic [COLOR_SIZE-1:0]   out_color_o
`ifdef Z_TEST_STATS_EN
  ,
  output logic [31:0]             stat_pass_o,
  output logic [31:0]             stat_fail_o
`endif
);

  localparam int unsigned FRAG_W = X_PIXEL_SIZE + Y_PIXEL_SIZE + Z_SIZE + COLOR_SIZE;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned Z_LSB  = COLOR_SIZE;
  localparam int unsigned Y_LSB  = Z_LSB + Z_SIZE;
  localparam int unsigned X_LSB  = Y_LSB + Y_PIXEL_SIZE;

  disp_state_t       state_q, state_d;
  logic              push_c, pop_c, issue_c, load_out_c, flush_done_c;
  logic              start_d, flush_sel_d, out_valid_d;
  logic              flush_pending_q, flush_pending_d;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt, cnt_next;
  logic [FRAG_W-1:0] fifo_wdata, fifo_rdata;
  z_func_t           zb_func_q;
  logic [COLOR_SIZE-1:0] color_q;

  assign push_c     = frag_valid_i && frag_ready_o && !fifo_full;
  assign fifo_wdata = {frag_x_i, frag_y_i, frag_z_i, frag_color_i};
  assign zb_func_o  = zb_func_q;

  frag_fifo #(
    .WIDTH (FRAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_c),
    .data_i  (fifo_wdata),
    .pop_i   (pop_c),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Flush request bookkeeping and post-update FIFO occupancy for the ready register.
  always_comb begin
    flush_pending_d = flush_pending_q;
    if (flush_done_c) flush_pending_d = 1'b0;
    else if (flush_req_i && (state_q != ST_FLUSH_WAIT)) flush_pending_d = 1'b1;
    cnt_next = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and command decode; queued fragments drain ahead of a pending flush.
  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    flush_sel_d  = 1'b0;
    pop_c        = 1'b0;
    issue_c      = 1'b0;
    load_out_c   = 1'b0;
    flush_done_c = 1'b0;
    out_valid_d  = out_valid_o;
    case (state_q)
      ST_IDLE: begin
        if (flush_pending_q && fifo_empty) begin
          start_d     = 1'b1;
          flush_sel_d = 1'b1;
          state_d     = ST_FLUSH_WAIT;
        end else if (!fifo_empty) begin
          pop_c   = 1'b1;
          issue_c = 1'b1;
          start_d = 1'b1;
          state_d = ST_TEST_WAIT;
        end
      end
      ST_TEST_WAIT: begin
        if (zb_done_i) begin
          if (zb_pass_i) begin
            load_out_c  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_EMIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_FLUSH_WAIT: begin
        if (zb_done_i) begin
          flush_done_c = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered control outputs; ready reflects occupancy after this cycle's push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zb_start_o      <= 1'b0;
      zb_flush_o      <= 1'b0;
      out_valid_o     <= 1'b0;
      flush_pending_q <= 1'b0;
      flush_busy_o    <= 1'b0;
      frag_ready_o    <= 1'b1;
    end else begin
      zb_start_o      <= start_d;
      zb_flush_o      <= flush_sel_d;
      out_valid_o     <= out_valid_d;
      flush_pending_q <= flush_pending_d;
      flush_busy_o    <= flush_pending_d || (state_d == ST_FLUSH_WAIT);
      frag_ready_o    <= (cnt_next != CNT_W'(FIFO_DEPTH)) && !flush_pending_d;
    end
  end

  // Issued fragment held until done; output register loaded only on a pass.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zb_x_o      <= '0;
      zb_y_o      <= '0;
      zb_z_o      <= '0;
      zb_func_q   <= Z_NEVER;
      color_q     <= '0;
      out_x_o     <= '0;
      out_y_o     <= '0;
      out_z_o     <= '0;
      out_color_o <= '0;
    end else begin
      if (issue_c) begin
        zb_x_o    <= fifo_rdata[X_LSB +: X_PIXEL_SIZE];
        zb_y_o    <= fifo_rdata[Y_LSB +: Y_PIXEL_SIZE];
        zb_z_o    <= fifo_rdata[Z_LSB +: Z_SIZE];
        color_q   <= fifo_rdata[0 +: COLOR_SIZE];
        zb_func_q <= z_func_t'(depth_func_i);
      end
      if (load_out_c) begin
        out_x_o     <= zb_x_o;
        out_y_o     <= zb_y_o;
        out_z_o     <= zb_z_o;
        out_color_o <= color_q;
      end
    end
  end

`ifdef Z_TEST_STATS_EN
  // Saturating pass/fail counters, cleared when a flush completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_pass_o <= '0;
      stat_fail_o <= '0;
    end else if (flush_done_c) begin
      stat_pass_o <= '0;
      stat_fail_o <= '0;
    end else if ((state_q == ST_TEST_WAIT) && zb_done_i) begin
      if (zb_pass_i) begin
        if (stat_pass_o != '1) stat_pass_o <= stat_pass_o + 32'd1;
      end else begin
        if (stat_fail_o != '1) stat_fail_o <= stat_fail_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_z_test_dispatcher.sv
module tb_z_test_dispatcher;
  import rast_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        frag_valid_i, frag_ready_o;
  logic [1:0]  frag_x_i, frag_y_i;
  logic [7:0]  frag_z_i;
  logic [15:0] frag_color_i;
  logic [2:0]  depth_func_i;
  logic        flush_req_i, flush_busy_o;
  logic        zb_start_o, zb_flush_o;
  logic [1:0]  zb_x_o, zb_y_o;
  logic [7:0]  zb_z_o;
  logic [2:0]  zb_func_o;
  logic        zb_done_i, zb_pass_i;
  logic        out_valid_o, out_ready_i;
  logic [1:0]  out_x_o, out_y_o;
  logic [7:0]  out_z_o;
  logic [15:0] out_color_o;
`ifdef Z_TEST_STATS_EN
  logic [31:0] stat_pass_o, stat_fail_o;
`endif

  always #5 clk_i = ~clk_i;

  z_test_dispatcher dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .frag_valid_i (frag_valid_i),
    .frag_ready_o (frag_ready_o),
    .frag_x_i     (frag_x_i),
    .frag_y_i     (frag_y_i),
    .frag_z_i     (frag_z_i),
    .frag_color_i (frag_color_i),
    .depth_func_i (depth_func_i),
    .flush_req_i  (flush_req_i),
    .flush_busy_o (flush_busy_o),
    .zb_start_o   (zb_start_o),
    .zb_flush_o   (zb_flush_o),
    .zb_x_o       (zb_x_o),
    .zb_y_o       (zb_y_o),
    .zb_z_o       (zb_z_o),
    .zb_func_o    (zb_func_o),
    .zb_done_i    (zb_done_i),
    .zb_pass_i    (zb_pass_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_x_o      (out_x_o),
    .out_y_o      (out_y_o),
    .out_z_o      (out_z_o),
    .out_color_o  (out_color_o)
`ifdef Z_TEST_STATS_EN
    ,
    .stat_pass_o  (stat_pass_o),
    .stat_fail_o  (stat_fail_o)
`endif
  );

  typedef struct packed {
    logic    flush;
    logic    pass;
    z_func_t func;
    frag_t   f;
  } issue_t;

  issue_t issue_q[$];
  frag_t  exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     emit_cnt = 0;
  int     start_cnt = 0;
  int     n_issue_exp = 0;
  int     resp_delay = 2;
  logic   resp_busy = 1'b0;
  logic   ready_en = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one fragment; record the expected z_buffer command and, if it will pass, the output.
  task automatic push_frag(input logic [1:0] x, input logic [1:0] y, input logic [7:0] z,
                           input logic [15:0] c, input logic pass);
    frag_t  f;
    issue_t e;
    logic   accepted;
    f.x = x; f.y = y; f.z = z; f.color = c;
    e.flush = 1'b0; e.pass = pass; e.func = z_func_t'(depth_func_i); e.f = f;
    issue_q.push_back(e);
    n_issue_exp++;
    if (pass) exp_q.push_back(f);
    @(posedge clk_i); #1;
    frag_valid_i = 1'b1; frag_x_i = x; frag_y_i = y; frag_z_i = z; frag_color_i = c;
    accepted = 1'b0;
    for (int k = 0; k < 300 && !accepted; k++) begin
      @(negedge clk_i);
      accepted = frag_ready_o;
      @(posedge clk_i); #1;
    end
    frag_valid_i = 1'b0;
    if (!accepted) check_eq("push_timeout", 0, 1);
  endtask

  task automatic do_flush();
    issue_t e;
    e.flush = 1'b1; e.pass = 1'b0; e.func = Z_NEVER; e.f = '0;
    issue_q.push_back(e);
    n_issue_exp++;
    @(posedge clk_i); #1; flush_req_i = 1'b1;
    @(posedge clk_i); #1; flush_req_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk_i);
      done = (issue_q.size() == 0) && (exp_q.size() == 0) && !resp_busy &&
             !flush_busy_o && !out_valid_o;
    end
    if (!done) check_eq(tag, 0, 1);
    repeat (2) @(negedge clk_i);
  endtask

  // z_buffer stand-in: checks each command against the scoreboard, answers after resp_delay.
  initial begin : responder
    issue_t e;
    logic   aborted;
    zb_done_i = 1'b0;
    zb_pass_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (zb_start_o) begin
        if (issue_q.size() == 0) begin
          check_eq("start_unexpected", 1, 0);
        end else begin
          e = issue_q.pop_front();
          resp_busy = 1'b1;
          check_eq("zb_flush", 64'(zb_flush_o), 64'(e.flush));
          if (!e.flush) begin
            check_eq("zb_xyz", 64'({zb_x_o, zb_y_o, zb_z_o}), 64'({e.f.x, e.f.y, e.f.z}));
            check_eq("zb_func", 64'(zb_func_o), 64'(e.func));
          end
          aborted = 1'b0;
          for (int k = 0; k < resp_delay; k++) begin
            @(posedge clk_i); #1;
            if (!rst_ni) aborted = 1'b1;
          end
          if (!aborted && rst_ni) begin
            zb_done_i = 1'b1;
            zb_pass_i = e.pass;
            @(posedge clk_i); #1;
            zb_done_i = 1'b0;
            zb_pass_i = 1'b0;
          end
          resp_busy = 1'b0;
        end
      end
    end
  end

  initial begin : start_counter
    forever begin
      @(negedge clk_i);
      if (zb_start_o) start_cnt++;
    end
  end

  initial begin : emit_monitor
    frag_t f;
    forever begin
      @(negedge clk_i);
      if (out_valid_o && out_ready_i) begin
        emit_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("emit_unexpected", 1, 0);
        end else begin
          f = exp_q.pop_front();
          check_eq("emit", 64'({out_x_o, out_y_o, out_z_o, out_color_o}), 64'(f));
        end
      end
    end
  end

  initial begin : ready_driver
    out_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      out_ready_i = ready_en && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int   base_e;
    int   base_s;
    int   bad;
    logic ended;
    rst_ni = 1'b0; frag_valid_i = 1'b0; frag_x_i = '0; frag_y_i = '0; frag_z_i = '0;
    frag_color_i = '0; depth_func_i = Z_LESS; flush_req_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;

    // Reset values
    check_eq("rst_frag_ready", 64'(frag_ready_o), 1);
    check_eq("rst_flush_busy", 64'(flush_busy_o), 0);
    check_eq("rst_zb_start",   64'({zb_start_o, zb_flush_o}), 0);
    check_eq("rst_out_valid",  64'(out_valid_o), 0);
    check_eq("rst_zb_fields",  64'({zb_x_o, zb_y_o, zb_z_o, zb_func_o}), 0);
    check_eq("rst_out_fields", 64'({out_x_o, out_y_o, out_z_o, out_color_o}), 0);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i); #1;

    // Single passing fragment with latency and pulse-width checks
    ready_en = 1'b1; resp_delay = 2; base_e = emit_cnt;
    push_frag(2'd1, 2'd2, 8'd10, 16'hBEEF, 1'b1);
    @(negedge clk_i); check_eq("lat_cycle1", 64'(zb_start_o), 0);
    @(negedge clk_i); check_eq("lat_cycle2", 64'(zb_start_o), 1);
    @(negedge clk_i); check_eq("start_one_cycle", 64'(zb_start_o), 0);
    wait_drain("t1_drain_timeout");
    check_eq("t1_emits", 64'(emit_cnt - base_e), 1);

    // Failing fragment is dropped
    base_e = emit_cnt;
    push_frag(2'd3, 2'd0, 8'd200, 16'h1234, 1'b0);
    wait_drain("t2_drain_timeout");
    check_eq("t2_emits", 64'(emit_cnt - base_e), 0);
    check_eq("t2_idle_ready", 64'(frag_ready_o), 1);

    // Back-pressure fills the FIFO; order preserved afterwards
    ready_en = 1'b0; resp_delay = 6; depth_func_i = Z_GEQUAL;
    push_frag(2'd0, 2'd1, 8'd11, 16'hA001, 1'b1);
    push_frag(2'd1, 2'd1, 8'd22, 16'hA002, 1'b1);
    push_frag(2'd2, 2'd1, 8'd33, 16'hA003, 1'b0);
    push_frag(2'd3, 2'd1, 8'd44, 16'hA004, 1'b1);
    push_frag(2'd0, 2'd3, 8'd55, 16'hA005, 1'b1);
    @(negedge clk_i); check_eq("t3_full_ready", 64'(frag_ready_o), 0);
    fork
      begin repeat (30) @(posedge clk_i); #1; ready_en = 1'b1; end
    join_none
    push_frag(2'd3, 2'd3, 8'd66, 16'hA006, 1'b1);
    wait_drain("t3_drain_timeout");

    // Flush waits for queued fragments; upstream blocked meanwhile
    resp_delay = 3;
    push_frag(2'd2, 2'd2, 8'd77, 16'hB001, 1'b1);
    push_frag(2'd1, 2'd3, 8'd88, 16'hB002, 1'b0);
    do_flush();
    @(negedge clk_i);
    check_eq("t4_busy", 64'(flush_busy_o), 1);
    check_eq("t4_ready_blocked", 64'(frag_ready_o), 0);
    bad = 0; ended = 1'b0;
    for (int k = 0; k < 300 && !ended; k++) begin
      @(negedge clk_i);
      if (!flush_busy_o) ended = 1'b1;
      else if (frag_ready_o) bad++;
    end
    check_eq("t4_flush_ended", 64'(ended), 1);
    check_eq("t4_ready_low_in_flush", 64'(bad), 0);
    wait_drain("t4_drain_timeout");
    check_eq("t4_ready_after", 64'(frag_ready_o), 1);

    // Reset during TEST_WAIT
    resp_delay = 40; base_e = emit_cnt;
    push_frag(2'd2, 2'd3, 8'd55, 16'hCAFE, 1'b1);
    ended = 1'b0;
    for (int k = 0; k < 50 && !ended; k++) begin
      @(negedge clk_i);
      ended = resp_busy;
    end
    check_eq("t5_started", 64'(ended), 1);
    repeat (3) @(posedge clk_i); #1;
    rst_ni = 1'b0; #1;
    check_eq("t5_rst_ready", 64'(frag_ready_o), 1);
    check_eq("t5_rst_ctrl", 64'({zb_start_o, zb_flush_o, out_valid_o, flush_busy_o}), 0);
    check_eq("t5_rst_zb", 64'({zb_x_o, zb_y_o, zb_z_o, zb_func_o}), 0);
    exp_q.delete();
    issue_q.delete();
    repeat (3) @(posedge clk_i); #1;
    rst_ni = 1'b1;
    base_s = start_cnt;
    repeat (60) @(negedge clk_i);
    check_eq("t5_no_stale_emit", 64'(emit_cnt - base_e), 0);
    check_eq("t5_no_stale_start", 64'(start_cnt - base_s), 0);
    resp_delay = 1;
    push_frag(2'd0, 2'd0, 8'd1, 16'h0001, 1'b1);
    wait_drain("t5_drain_timeout");
    check_eq("t5_alive_emit", 64'(emit_cnt - base_e), 1);

`ifdef Z_TEST_STATS_EN
    do_flush();
    wait_drain("st_flush0_timeout");
    push_frag(2'd0, 2'd1, 8'd5, 16'hC001, 1'b1);
    push_frag(2'd1, 2'd1, 8'd6, 16'hC002, 1'b0);
    push_frag(2'd2, 2'd1, 8'd7, 16'hC003, 1'b1);
    push_frag(2'd3, 2'd1, 8'd8, 16'hC004, 1'b0);
    push_frag(2'd0, 2'd2, 8'd9, 16'hC005, 1'b1);
    wait_drain("st_drain_timeout");
    check_eq("stat_pass", 64'(stat_pass_o), 3);
    check_eq("stat_fail", 64'(stat_fail_o), 2);
    do_flush();
    wait_drain("st_flush1_timeout");
    check_eq("stat_pass_clr", 64'(stat_pass_o), 0);
    check_eq("stat_fail_clr", 64'(stat_fail_o), 0);
`endif

    check_eq("start_total", 64'(start_cnt), 64'(n_issue_exp));
    check_eq("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
